// File: rtl/fa_bist_pkg.sv
// Shared types and sizes for the full-adder self-test checker.
package fa_bist_pkg;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned NUM_VEC = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/fa_bist_checker_if.sv
// Request/status and adder-under-test signals of the self-test checker.
interface fa_bist_checker_if;
  import fa_bist_pkg::*;

  logic             start;
  logic             co_i;
  logic             s_i;
  logic             a_o;
  logic             b_o;
  logic             ci_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [VEC_W-1:0] first_fail;
  logic             fail_valid;

  // Requester / adder side: issues start, returns adder responses.
  modport master (
    output start, co_i, s_i,
    input  a_o, b_o, ci_o, busy, done, pass, err_cnt, first_fail, fail_valid
  );

  // Checker side.
  modport slave (
    input  start, co_i, s_i,
    output a_o, b_o, ci_o, busy, done, pass, err_cnt, first_fail, fail_valid
  );

endinterface

// File: rtl/fa_golden_model.sv
// Combinational reference full adder: expected {co, s} for a 3-bit vector.
module fa_golden_model
  import fa_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [1:0]       expected
);

  logic a, b, ci;

  // Bit 2 is a, bit 1 is b, bit 0 is carry-in.
  always_comb begin
    a        = vec[2];
    b        = vec[1];
    ci       = vec[0];
    expected = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  end

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive self-test of an external full adder: walks all 8 input vectors,
// lets each settle, samples the response and tallies mismatches.
module fa_bist_checker
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4  // legal range 1..15
) (
  input logic               clk,
  input logic               rst,
  fa_bist_checker_if.slave  bus
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] first_q, first_d;
  logic             fv_q, fv_d;
  logic [1:0]       expected;
  logic             mismatch;
  logic             active;

  fa_golden_model u_golden (
    .vec      (vec_q),
    .expected (expected)
  );

  // Response compare against the reference for the vector being driven.
  always_comb begin
    mismatch = ({bus.co_i, bus.s_i} != expected);
  end

  // Next-state logic for the sequencer and the error record.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    first_d  = first_q;
    fv_d     = fv_q;
    case (state_q)
      // A start in DONE restarts exactly like one from IDLE.
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = APPLY;
          vec_d    = '0;
          settle_d = '0;
          err_d    = '0;
          first_d  = '0;
          fv_d     = 1'b0;
        end
      end
      APPLY: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          // At most one error per vector, so the count tops out at NUM_VEC.
          err_d = err_q + ERR_W'(1);
          if (!fv_q) begin
            first_d = vec_q;
            fv_d    = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vec_d    = vec_q + VEC_W'(1);
          settle_d = '0;
          state_d  = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      first_q  <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      first_q  <= first_d;
      fv_q     <= fv_d;
    end
  end

  // Outputs decoded from state; stimulus is forced to zero when not running.
  always_comb begin
    active         = (state_q == APPLY) || (state_q == SAMPLE);
    {bus.a_o, bus.b_o, bus.ci_o} = active ? vec_q : '0;
    bus.busy       = active;
    bus.done       = (state_q == DONE);
    bus.pass       = (state_q == DONE) && (err_q == '0);
    bus.err_cnt    = err_q;
    bus.first_fail = first_q;
    bus.fail_valid = fv_q;
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Self-checking bench for fa_bist_checker: emulated adder with fault modes,
// scoreboard of expected vector order and per-run results.
module tb_fa_bist_checker;

  typedef struct packed {
    logic [3:0] err;
    logic [2:0] first;
    logic       fv;
    logic       pass;
  } fin_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fa_bist_checker_if bus0 ();
  fa_bist_checker_if bus1 ();

  fa_bist_checker #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fa_bist_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks     = 0;
  int failures   = 0;
  int fault_mode = 0;  // 0 correct, 1 s stuck at 0, 2 co inverted
  int sel        = 0;

  logic [2:0] vec_sb[$];
  fin_t       fin_q[$];

  // Adder under test, with optional planted fault.
  function automatic logic [1:0] adder_resp(input logic [2:0] v, input int mode);
    logic a, b, c, co, s;
    a  = v[2];
    b  = v[1];
    c  = v[0];
    co = (a & b) | (a & c) | (b & c);
    s  = a ^ b ^ c;
    if (mode == 1) s = 1'b0;
    if (mode == 2) co = ~co;
    return {co, s};
  endfunction

  always_comb begin
    {bus0.co_i, bus0.s_i} = adder_resp({bus0.a_o, bus0.b_o, bus0.ci_o}, fault_mode);
    {bus1.co_i, bus1.s_i} = adder_resp({bus1.a_o, bus1.b_o, bus1.ci_o}, fault_mode);
  end

  logic [2:0] o_stim;
  logic       o_busy, o_done, o_pass, o_fv;
  logic [3:0] o_err;
  logic [2:0] o_first;

  always_comb begin
    if (sel == 0) begin
      o_stim  = {bus0.a_o, bus0.b_o, bus0.ci_o};
      o_busy  = bus0.busy;
      o_done  = bus0.done;
      o_pass  = bus0.pass;
      o_fv    = bus0.fail_valid;
      o_err   = bus0.err_cnt;
      o_first = bus0.first_fail;
    end else begin
      o_stim  = {bus1.a_o, bus1.b_o, bus1.ci_o};
      o_busy  = bus1.busy;
      o_done  = bus1.done;
      o_pass  = bus1.pass;
      o_fv    = bus1.fail_valid;
      o_err   = bus1.err_cnt;
      o_first = bus1.first_fail;
    end
  end

  task automatic set_start(input int which, input logic v);
    if (which == 0) bus0.start = v;
    else bus1.start = v;
  endtask

  // One full run: scoreboard filled up front, then checked cycle by cycle.
  task automatic do_run(input int which, input int s, input int mode, input bit poke,
                        input string tag);
    logic [3:0] e_err;
    logic [2:0] e_first, vv, exp_v;
    logic       e_fv;
    logic [1:0] ideal, got;
    fin_t       f;
    int         n_tot;
    sel        = which;
    fault_mode = mode;
    e_err      = 4'd0;
    e_first    = 3'd0;
    e_fv       = 1'b0;
    for (int v = 0; v < 8; v++) begin
      vv    = 3'(v);
      ideal = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
      got   = adder_resp(vv, mode);
      if (ideal != got) begin
        e_err = e_err + 4'd1;
        if (!e_fv) begin
          e_first = vv;
          e_fv    = 1'b1;
        end
      end
      vec_sb.push_back(vv);
    end
    f.err   = e_err;
    f.first = e_first;
    f.fv    = e_fv;
    f.pass  = (e_err == 4'd0);
    fin_q.push_back(f);
    n_tot = 8 * (s + 1);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    for (int n = 1; n <= n_tot + 1; n++) begin
      @(negedge clk);
      set_start(which, poke && (n == 7));
      if (n <= n_tot) begin
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_pass !== 1'b0) begin
          failures++;
          $display("FAIL %s run_status n=%0d: busy=%b done=%b pass=%b, required 1 0 0",
                   tag, n, o_busy, o_done, o_pass);
        end
        if (n % (s + 1) == 0) begin
          exp_v = vec_sb.pop_front();
          checks++;
          if (o_stim !== exp_v) begin
            failures++;
            $display("FAIL %s vector n=%0d: got %b required %b", tag, n, o_stim, exp_v);
          end
        end
      end else begin
        f = fin_q.pop_front();
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_stim !== 3'b000) begin
          failures++;
          $display("FAIL %s done_cycle n=%0d: done=%b busy=%b stim=%b, required 1 0 000",
                   tag, n, o_done, o_busy, o_stim);
        end
        checks++;
        if (o_pass !== f.pass) begin
          failures++;
          $display("FAIL %s pass: got %b required %b", tag, o_pass, f.pass);
        end
        checks++;
        if (o_err !== f.err) begin
          failures++;
          $display("FAIL %s err_cnt: got %0d required %0d", tag, o_err, f.err);
        end
        checks++;
        if (o_fv !== f.fv) begin
          failures++;
          $display("FAIL %s fail_valid: got %b required %b", tag, o_fv, f.fv);
        end
        if (f.fv) begin
          checks++;
          if (o_first !== f.first) begin
            failures++;
            $display("FAIL %s first_fail: got %0d required %0d", tag, o_first, f.first);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      sel = w;
      #1;
      checks++;
      if ({o_stim, o_busy, o_done, o_pass, o_err, o_first, o_fv} !== 16'd0) begin
        failures++;
        $display("FAIL reset_state inst=%0d: stim=%b busy=%b done=%b pass=%b err=%0d first=%0d fv=%b, required all 0",
                 w, o_stim, o_busy, o_done, o_pass, o_err, o_first, o_fv);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    do_run(0, 4, 0, 1'b0, "clean");
  endtask

  task automatic test_s_stuck();
    do_run(0, 4, 1, 1'b0, "s_stuck0");
  endtask

  task automatic test_co_inv();
    do_run(0, 4, 2, 1'b0, "co_inverted");
  endtask

  task automatic test_start_ignored();
    do_run(0, 4, 1, 1'b1, "start_midrun");
  endtask

  task automatic test_back_to_back();
    do_run(0, 4, 0, 1'b0, "b2b_first");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1 || o_pass !== 1'b1) begin
        failures++;
        $display("FAIL done_hold k=%0d: done=%b pass=%b, required 1 1", k, o_done, o_pass);
      end
    end
    do_run(0, 4, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_midrun();
    sel        = 0;
    fault_mode = 2;
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      bus0.start = 1'b0;
    end
    checks++;
    if (o_stim !== 3'd3 || o_err !== 4'd3) begin
      failures++;
      $display("FAIL pre_reset: stim=%0d err=%0d, required 3 3", o_stim, o_err);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({o_stim, o_busy, o_done, o_pass, o_err, o_first, o_fv} !== 16'd0) begin
      failures++;
      $display("FAIL midrun_reset: stim=%b busy=%b done=%b pass=%b err=%0d first=%0d fv=%b, required all 0",
               o_stim, o_busy, o_done, o_pass, o_err, o_first, o_fv);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_stim !== 3'd0) begin
        failures++;
        $display("FAIL no_resume k=%0d: busy=%b done=%b stim=%b, required 0 0 000",
                 k, o_busy, o_done, o_stim);
      end
    end
    do_run(0, 4, 0, 1'b0, "after_reset");
  endtask

  task automatic test_settle1();
    do_run(1, 1, 0, 1'b0, "settle1");
    do_run(1, 1, 1, 1'b0, "settle1_stuck");
  endtask

  initial begin
    test_reset();
    test_clean();
    test_s_stuck();
    test_co_inv();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_settle1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fa_bist_checker.md
FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles each vector is driven before the response is sampled; legal range 1..15.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle request to begin a self-test run.
REQ-006 co_i  input  1  carry-out returned by the adder under test.
REQ-007 s_i  input  1  sum returned by the adder under test.
REQ-008 a_o, b_o, ci_o  output  1 each  stimulus driven to the adder under test.
REQ-009 busy  output  1  run in progress.
REQ-010 done  output  1  run complete; held until the next start.
REQ-011 pass  output  1  valid while done=1; 1 when no mismatches were found.
REQ-012 err_cnt  output  4  number of mismatching vectors, range 0..8.
REQ-013 first_fail  output  3  index of the first failing vector; valid while fail_valid=1.
REQ-014 fail_valid  output  1  at least one mismatch has been recorded in this run.

Function
REQ-015 State machine SHALL have states IDLE, APPLY, SAMPLE and DONE.
REQ-016 IDLE: on start=1, go to APPLY with vec=0, settle counter=0, err_cnt=0 and fail_valid=0.
REQ-017 {a_o,b_o,ci_o} SHALL equal vec (bit 2 drives a_o) in APPLY and SAMPLE, and 3'b000 in IDLE and DONE.
REQ-018 APPLY: increment the settle counter each cycle; after SETTLE_CYCLES cycles go to SAMPLE.
REQ-019 SAMPLE lasts exactly one cycle and compares {co_i,s_i} with the expected value {maj(a,b,ci), a^b^ci}.
REQ-020 On a mismatch in SAMPLE: increment err_cnt; if fail_valid=0, load first_fail=vec and set fail_valid=1.
REQ-021 Leaving SAMPLE: if vec=7 go to DONE, otherwise increment vec, clear the settle counter and go to APPLY; vec SHALL never wrap inside a run.
REQ-022 Each vector SHALL occupy SETTLE_CYCLES+1 cycles.
REQ-023 busy=1 SHALL hold from the cycle after start is sampled through the last SAMPLE cycle.
REQ-024 done=1 SHALL first appear 8*(SETTLE_CYCLES+1)+1 cycles after the start edge.
REQ-025 DONE: done=1 and pass=(err_cnt==0); err_cnt, first_fail and fail_valid hold.
REQ-026 A start in DONE SHALL begin a new run exactly as from IDLE, clearing done, pass and all counters on the same edge.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 pass SHALL be 0 whenever done=0.
REQ-029 err_cnt SHALL NOT exceed 8; its 4-bit width holds 8 without overflow.

Reset
REQ-030 rst=1 SHALL force IDLE, vec=0, settle counter=0, a_o/b_o/ci_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0 and fail_valid=0 on the next edge, from any state.
REQ-031 rst SHALL take priority over start on the same edge.
REQ-032 A run interrupted by reset SHALL NOT resume.

Structure
REQ-033 Package fa_bist_pkg SHALL hold the state enum, VEC_W=3, ERR_W=4 and NUM_VEC=8.
REQ-034 Sub-module fa_golden_model SHALL hold the combinational expected {co,s} for a 3-bit vector; it is also reused by benches.

Verification
REQ-035 Correct adder, SETTLE_CYCLES=4: start -> done at cycle 41, pass=1, err_cnt=0, fail_valid=0; all 8 vectors appear in order 0..7.
REQ-036 s_i stuck at 0 -> err_cnt=4 (vectors 1,2,4,7), first_fail=1, pass=0.
REQ-037 co_i inverted -> err_cnt=8, first_fail=0, pass=0.
REQ-038 rst pulsed while vec=3 -> next cycle all outputs 0 and state IDLE; a later start runs cleanly to pass=1.
REQ-039 start pulsed mid-run -> run timing unchanged; start in DONE -> counters clear and second run completes with the same results.
REQ-040 SETTLE_CYCLES=1, correct adder -> done at cycle 17, pass=1.
